// File: rtl/state_dump_unit_pkg.sv
// Shared types and constants for the state dump unit: FSM states, beat tags,
// beat payload layout and frame geometry.
package state_dump_unit_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned DM_ADDR_W = 8;

  localparam int unsigned DEF_NUM_REGS      = 32;
  localparam int unsigned DEF_NUM_MEM_WORDS = 8;
  localparam int unsigned DEF_MEM_STRIDE    = 4;

  // One header beat, then every register word, then every memory word.
  function automatic int unsigned frame_len(input int unsigned num_regs,
                                            input int unsigned num_mem_words);
    return 1 + num_regs + num_mem_words;
  endfunction

  localparam int unsigned FRAME_LEN = frame_len(DEF_NUM_REGS, DEF_NUM_MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    REG  = 2'd2,
    MEM  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TAG_HDR = 2'd0,
    TAG_REG = 2'd1,
    TAG_MEM = 2'd2
  } tag_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    tag_e              tag;
    logic              last;
  } beat_t;

endpackage

// File: rtl/state_dump_unit_if.sv
// Beat stream plus register-file / data-memory read ports of the dump unit.
interface state_dump_unit_if;
  import state_dump_unit_pkg::*;

  logic                 tx_valid_o;
  logic                 tx_ready_i;
  logic [DATA_W-1:0]    tx_data_o;
  logic [1:0]           tx_tag_o;
  logic                 tx_last_o;
  logic [RF_ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0]    rf_data_i;
  logic [DM_ADDR_W-1:0] dm_addr_o;
  logic [DATA_W-1:0]    dm_data_i;

  modport master (
    output tx_valid_o, tx_data_o, tx_tag_o, tx_last_o, rf_addr_o, dm_addr_o,
    input  tx_ready_i, rf_data_i, dm_data_i
  );

  modport slave (
    input  tx_valid_o, tx_data_o, tx_tag_o, tx_last_o, rf_addr_o, dm_addr_o,
    output tx_ready_i, rf_data_i, dm_data_i
  );

endinterface

// File: rtl/dump_cycle_counter.sv
// Saturating run-cycle counter captured into each dump frame header.
module dump_cycle_counter
  import state_dump_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/state_dump_unit.sv
// Streams a snapshot frame (cycle count, register file, data memory) as one
// beat per cycle over a valid/ready link while holding the CPU frozen.
module state_dump_unit
  import state_dump_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
  parameter int unsigned NUM_MEM_WORDS = DEF_NUM_MEM_WORDS,
  parameter int unsigned MEM_STRIDE    = DEF_MEM_STRIDE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              dump_req_i,
  output logic              busy_o,
  output logic              cpu_freeze_o,
  state_dump_unit_if.master bus
);

  localparam logic [RF_ADDR_W-1:0] REG_LAST = RF_ADDR_W'(NUM_REGS - 1);
  localparam logic [DM_ADDR_W-1:0] MEM_LAST = DM_ADDR_W'(NUM_MEM_WORDS - 1);

  state_e               state_q;
  beat_t                beat_q;
  logic                 busy_q;
  logic                 pending_q;
  logic [RF_ADDR_W-1:0] reg_idx_q;
  logic [RF_ADDR_W-1:0] rf_addr_q;
  logic [DM_ADDR_W-1:0] mem_idx_q;
  logic [DM_ADDR_W-1:0] dm_idx_q;
  logic [DATA_W-1:0]    cycle_count;

  logic                 xfer;
  logic                 frame_end;
  logic                 start_frame;
  logic [RF_ADDR_W-1:0] rf_addr_nxt;
  logic [DM_ADDR_W-1:0] dm_idx_nxt;
  logic [DM_ADDR_W-1:0] mem_idx_inc;

  dump_cycle_counter #(.WIDTH(DATA_W)) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (start_i & ~busy_q),
    .count_o (cycle_count)
  );

  // Read addresses run one word ahead of the presented beat and stop at the last index.
  always_comb begin
    xfer        = busy_q & bus.tx_ready_i;
    frame_end   = xfer && (state_q == MEM) && (mem_idx_q == MEM_LAST);
    start_frame = ((state_q == IDLE) && dump_req_i) ||
                  (frame_end && (pending_q || dump_req_i));
    rf_addr_nxt = (rf_addr_q == REG_LAST) ? REG_LAST : rf_addr_q + RF_ADDR_W'(1);
    dm_idx_nxt  = (dm_idx_q == MEM_LAST) ? MEM_LAST : dm_idx_q + DM_ADDR_W'(1);
    mem_idx_inc = mem_idx_q + DM_ADDR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      reg_idx_q <= '0;
      rf_addr_q <= '0;
      mem_idx_q <= '0;
      dm_idx_q  <= '0;
    end else if (start_frame) begin
      state_q   <= HDR;
      beat_q    <= '{data: cycle_count, tag: TAG_HDR, last: 1'b0};
      busy_q    <= 1'b1;
      pending_q <= 1'b0;
      reg_idx_q <= '0;
      rf_addr_q <= '0;
      mem_idx_q <= '0;
      dm_idx_q  <= '0;
    end else if (frame_end) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      reg_idx_q <= '0;
      rf_addr_q <= '0;
      mem_idx_q <= '0;
      dm_idx_q  <= '0;
    end else begin
      if (busy_q && dump_req_i) pending_q <= 1'b1;
      if (xfer) begin
        case (state_q)
          HDR: begin
            state_q   <= REG;
            beat_q    <= '{data: bus.rf_data_i, tag: TAG_REG, last: 1'b0};
            rf_addr_q <= rf_addr_nxt;
          end
          REG: begin
            if (reg_idx_q == REG_LAST) begin
              state_q  <= MEM;
              beat_q   <= '{data: bus.dm_data_i, tag: TAG_MEM, last: (MEM_LAST == '0)};
              dm_idx_q <= dm_idx_nxt;
            end else begin
              reg_idx_q <= reg_idx_q + RF_ADDR_W'(1);
              beat_q    <= '{data: bus.rf_data_i, tag: TAG_REG, last: 1'b0};
              rf_addr_q <= rf_addr_nxt;
            end
          end
          MEM: begin
            mem_idx_q <= mem_idx_inc;
            beat_q    <= '{data: bus.dm_data_i, tag: TAG_MEM, last: (mem_idx_inc == MEM_LAST)};
            dm_idx_q  <= dm_idx_nxt;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o         = busy_q;
  assign cpu_freeze_o   = busy_q;
  assign bus.tx_valid_o = busy_q;
  assign bus.tx_data_o  = beat_q.data;
  assign bus.tx_tag_o   = beat_q.tag;
  assign bus.tx_last_o  = beat_q.last;
  assign bus.rf_addr_o  = rf_addr_q;
  assign bus.dm_addr_o  = DM_ADDR_W'(dm_idx_q * MEM_STRIDE);

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench for state_dump_unit: scoreboard of expected beats checked
// against every transferred beat, plus directed checks on control outputs.
module tb_state_dump_unit;
  import state_dump_unit_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  tag;
    logic        last;
  } exp_t;

  logic clk_i;
  logic rst_i;
  logic start_i;
  logic dump_req_i;
  logic busy_o;
  logic cpu_freeze_o;

  state_dump_unit_if bus ();

  logic [31:0] rf_mem [DEF_NUM_REGS];
  logic [31:0] dm_mem [256];
  exp_t        exp_q [$];
  logic [31:0] obs_data [$];
  int          checks = 0;
  int          errors = 0;

  assign bus.rf_data_i = rf_mem[bus.rf_addr_o];
  assign bus.dm_data_i = dm_mem[bus.dm_addr_o];

  state_dump_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .dump_req_i   (dump_req_i),
    .busy_o       (busy_o),
    .cpu_freeze_o (cpu_freeze_o),
    .bus          (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] hdr);
    exp_q.push_back('{data: hdr, tag: 2'd0, last: 1'b0});
    for (int r = 0; r < 32; r++) exp_q.push_back('{data: rf_mem[r], tag: 2'd1, last: 1'b0});
    for (int m = 0; m < 8; m++) exp_q.push_back('{data: dm_mem[m*4], tag: 2'd2, last: (m == 7)});
  endtask

  // Called on a negedge; returns on the following negedge with the header presented.
  task automatic request(input logic [31:0] hdr);
    dump_req_i = 1'b1;
    push_frame(hdr);
    @(negedge clk_i);
    dump_req_i = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int exp_n);
    int n = 0;
    while (busy_o && n < 400) begin
      n++;
      @(negedge clk_i);
    end
    check(name, 64'(n), 64'(exp_n));
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_valid"},  64'(bus.tx_valid_o), 64'd0);
    check({pfx, "_busy"},   64'(busy_o),         64'd0);
    check({pfx, "_freeze"}, 64'(cpu_freeze_o),   64'd0);
    check({pfx, "_data"},   64'(bus.tx_data_o),  64'd0);
    check({pfx, "_tag"},    64'(bus.tx_tag_o),   64'd0);
    check({pfx, "_last"},   64'(bus.tx_last_o),  64'd0);
    check({pfx, "_rfaddr"}, 64'(bus.rf_addr_o),  64'd0);
    check({pfx, "_dmaddr"}, 64'(bus.dm_addr_o),  64'd0);
  endtask

  // Beat monitor: samples just before each posedge, where a valid&ready beat transfers.
  always @(negedge clk_i) begin : mon
    exp_t e;
    #4;
    if (rst_i && bus.tx_valid_o && bus.tx_ready_i) begin
      obs_data.push_back(bus.tx_data_o);
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", 64'(bus.tx_data_o), 64'(e.data));
        check("beat_tag",  64'(bus.tx_tag_o),  64'(e.tag));
        check("beat_last", 64'(bus.tx_last_o), 64'(e.last));
      end
    end
  end

  initial begin
    int          n;
    logic        seen;
    logic [47:0] snap;

    rst_i          = 1'b0;
    start_i        = 1'b0;
    dump_req_i     = 1'b0;
    bus.tx_ready_i = 1'b1;
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h1000_0000 + 32'(r) * 32'h0101;
    rf_mem[8] = 32'd5;
    for (int a = 0; a < 256; a++) dm_mem[a] = 32'hD000_0000 | 32'(a);
    dm_mem[4] = 32'd7;

    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b1;

    // Count 10 run cycles, then dump with ready tied high.
    @(negedge clk_i);
    start_i = 1'b1;
    repeat (10) @(negedge clk_i);
    start_i = 1'b0;
    obs_data.delete();
    request(32'd10);
    check("hdr_busy",   64'(busy_o),         64'd1);
    check("hdr_freeze", 64'(cpu_freeze_o),   64'd1);
    check("hdr_valid",  64'(bus.tx_valid_o), 64'd1);
    check("hdr_tag",    64'(bus.tx_tag_o),   64'd0);
    check("hdr_data",   64'(bus.tx_data_o),  64'd10);
    finish_frame("frame_basic_cycles", 41);
    check("frame_basic_beats", 64'(obs_data.size()), 64'd41);
    check("reg_beat9_r8",      64'(obs_data[9]),     64'd5);
    check("mem_beat2_addr4",   64'(obs_data[34]),    64'd7);

    // Backpressure for three cycles during register beats.
    obs_data.delete();
    request(32'd10);
    n = 0;
    while (busy_o && n < 400) begin
      n++;
      if (n == 6) begin
        bus.tx_ready_i = 1'b0;
        snap = {bus.tx_data_o, bus.tx_tag_o, bus.tx_last_o, bus.rf_addr_o, bus.dm_addr_o};
        repeat (3) begin
          @(negedge clk_i);
          n++;
          check("stall_hold",  {16'd0, bus.tx_data_o, bus.tx_tag_o, bus.tx_last_o,
                                bus.rf_addr_o, bus.dm_addr_o}, {16'd0, snap});
          check("stall_valid", 64'(bus.tx_valid_o), 64'd1);
        end
        bus.tx_ready_i = 1'b1;
      end
      @(negedge clk_i);
    end
    check("frame_stall_cycles", 64'(n), 64'd44);
    check("frame_stall_drained", 64'(exp_q.size()), 64'd0);
    check("frame_stall_beats", 64'(obs_data.size()), 64'd41);

    // Two requests during a frame give exactly one back-to-back frame; counter frozen.
    start_i = 1'b1;
    repeat (3) @(negedge clk_i);
    start_i = 1'b0;
    request(32'd13);
    start_i = 1'b1;
    n = 0;
    while (busy_o && n < 400) begin
      n++;
      if (n == 5) begin
        dump_req_i = 1'b1;
        push_frame(32'd13);
      end
      if (n == 6)  dump_req_i = 1'b0;
      if (n == 10) dump_req_i = 1'b1;
      if (n == 11) dump_req_i = 1'b0;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    check("pending_cycles", 64'(n), 64'd82);
    check("pending_drained", 64'(exp_q.size()), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      seen = seen | busy_o | bus.tx_valid_o;
    end
    check("pending_no_third", 64'(seen), 64'd0);

    // Request arriving with the last-beat transfer chains a new frame.
    request(32'd13);
    n = 0;
    while (busy_o && n < 400) begin
      n++;
      dump_req_i = 1'b0;
      if (n == 41) begin
        check("simul_last_at_41", 64'(bus.tx_last_o), 64'd1);
        dump_req_i = 1'b1;
        push_frame(32'd13);
      end
      @(negedge clk_i);
    end
    dump_req_i = 1'b0;
    check("simul_cycles", 64'(n), 64'd82);
    check("simul_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while beat 20 is presented.
    request(32'd13);
    repeat (19) @(negedge clk_i);
    check("pre_reset_valid", 64'(bus.tx_valid_o), 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    obs_data.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      seen = seen | busy_o | bus.tx_valid_o;
    end
    check("no_beat_after_reset", 64'(seen), 64'd0);
    request(32'd0);
    finish_frame("frame_after_reset", 41);

    // Counter saturation.
    force dut.u_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_cnt.count_q;
    start_i = 1'b1;
    repeat (5) @(negedge clk_i);
    start_i = 1'b0;
    request(32'hFFFF_FFFF);
    check("sat_hdr", 64'(bus.tx_data_o), 64'hFFFF_FFFF);
    finish_frame("frame_sat", 41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
